rtc_write_sequencer: RTL
========================

Name: rtc_write_sequencer

Overview:
- Commits the edited RTC parameter bytes (date/time and timer) to the RTC chip as a burst of single-byte register writes.
- Sits between the parameter-entry block, which supplies s/m/h/d/me/a/st/mt/ht, and the RTC bus transaction engine.
- Snapshots the bytes on start, walks the register map, then ends with a commit write so the chip transfers its shadow registers.

Parameters:
- ADDR_DT, 8'h21, base address of the date/time group (s,m,h,d,me,a at base+0..5).
- ADDR_TMR, 8'h41, base address of the timer group (st,mt,ht at base+0..2).
- ADDR_COMMIT, 8'hF1, commit/transfer command register address.
- DATA_COMMIT, 8'h00, data byte sent with the commit write.
- TIMEOUT, 255, maximum cycles to wait for wr_ack per write (8-bit counter).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  single-cycle request to write the selected groups
- sel  in  2  group select: 01 date/time, 10 timer, 11 both (date/time first), 00 no-op
- s, m, h, d, me, a, st, mt, ht  in  8 each  parameter bytes (BCD, passed through unmodified)
- wr_ack  in  1  bus engine accepted the current write
- wr_req  out  1  write request
- wr_addr  out  8  register address
- wr_data  out  8  register data
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse: all writes including commit acknowledged
- err  out  1  one-cycle pulse: ack timeout, sequence abandoned

Behaviour:
- Reset (rst low, asynchronous): state IDLE; wr_req=0, wr_addr=0, wr_data=0, busy=0, done=0, err=0, index=0, timeout counter=0, snapshot registers=0.
- All outputs are registered.
- IDLE:
  - On an edge with start=1 and sel!=00: latch all 9 bytes and sel into the snapshot, set index to the first write of the selected list, go to REQ. busy and wr_req rise after that same edge (1-cycle latency).
  - start with sel=00 is ignored; no done pulse.
- Write list, in order:
  - sel=01: ADDR_DT+0..5 carrying s,m,h,d,me,a, then the commit. 7 writes.
  - sel=10: ADDR_TMR+0..2 carrying st,mt,ht, then the commit. 4 writes.
  - sel=11: the 6 date/time writes, the 3 timer writes, then one commit. 10 writes.
- REQ:
  - wr_req=1; wr_addr and wr_data stay stable until acknowledged. The timeout counter increments each cycle.
  - On an edge with wr_ack=1: wr_req falls, the counter clears, go to GAP. If this was the commit write, go to DONE instead.
  - If the counter reaches TIMEOUT with no ack: wr_req falls, go to ERR.
- GAP: exactly one cycle with wr_req=0. Advance the index and load the next addr/data, then go to REQ.
- DONE: done=1 for one cycle, busy falls on the same edge, return to IDLE.
- ERR: err=1 for one cycle, busy falls, return to IDLE. done is not asserted.
- A pulse is never followed by the other pulse for the same start.
- start while busy=1 is ignored; no queuing.
- Input bytes changing during the sequence have no effect; the snapshot is used.
- wr_ack while not in REQ is ignored.
- wr_ack in the same cycle that the counter hits TIMEOUT counts as an ack; ack has priority.
- Address arithmetic is 8-bit; base+offset wraps modulo 256 with no carry or flag.
- Reset asserted mid-sequence aborts immediately. wr_req drops asynchronously, and no done or err is issued.

Test Plan:
- sel=01, s=8'h30 m=8'h45 h=8'h12 d=8'h07 me=8'h03 a=8'h16, wr_ack returned 1 cycle after each wr_req -> addresses 21,22,23,24,25,26,F1 with data 30,45,12,07,03,16,00. Exactly one wr_req=0 cycle between writes. done pulses once; busy high from the cycle after start until the done edge.
- sel=11, ack delayed 5 cycles each -> 10 writes: 21..26, 41,42,43, F1. Timer data equals st/mt/ht. Single commit at the end.
- sel=10, TIMEOUT=4, wr_ack never asserted -> wr_req=1 with addr 41 for 4 cycles, then falls. err pulses once; done stays 0; busy falls.
- Change s to 8'h59 and pulse start again during a sel=01 sequence -> written data still the original snapshot. Second start ignored: total writes = 7, one done.
- Pull rst low during the 3rd write -> all outputs 0 immediately. After release with start/sel=10 -> clean sequence 41,42,43,F1.
- start with sel=00 -> no wr_req, busy stays 0, no done or err.

Source files
------------

// File: rtl/rtc_write_sequencer.sv
`default_nettype none
// rtc_write_sequencer: snapshots RTC parameter bytes on start and issues them as single-byte
// register writes, ending with a commit write. Rev 1.0
module rtc_write_sequencer #(
  parameter logic [7:0]  ADDR_DT     = 8'h21,
  parameter logic [7:0]  ADDR_TMR    = 8'h41,
  parameter logic [7:0]  ADDR_COMMIT = 8'hF1,
  parameter logic [7:0]  DATA_COMMIT = 8'h00,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] sel,
  input  logic [7:0] s,
  input  logic [7:0] m,
  input  logic [7:0] h,
  input  logic [7:0] d,
  input  logic [7:0] me,
  input  logic [7:0] a,
  input  logic [7:0] st,
  input  logic [7:0] mt,
  input  logic [7:0] ht,
  input  logic       wr_ack,
  output logic       wr_req,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {IDLE, REQ, GAP, DONE, ERR} state_t;

  // Unified write list: 0..5 date/time, 6..8 timer, 9 commit.
  localparam logic [3:0] IDX_DT_LAST  = 4'd5;
  localparam logic [3:0] IDX_TMR      = 4'd6;
  localparam logic [3:0] IDX_COMMIT   = 4'd9;
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [3:0]      idx_q, idx_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [8:0][7:0] snap_q, snap_d;
  logic            tmr_q, tmr_d;
  logic            req_d, busy_d, done_d, err_d;
  logic [7:0]      addr_d, data_d;
  logic [8:0][7:0] live;

  assign live = {ht, mt, st, a, me, d, h, m, s};

  function automatic logic [7:0] addr_of(input logic [3:0] idx);
    if (idx < IDX_TMR)         addr_of = ADDR_DT + {4'd0, idx};
    else if (idx < IDX_COMMIT) addr_of = ADDR_TMR + {4'd0, 4'(idx - IDX_TMR)};
    else                       addr_of = ADDR_COMMIT;
  endfunction

  function automatic logic [7:0] data_of(input logic [3:0] idx, input logic [8:0][7:0] bytes);
    if (idx < IDX_COMMIT) data_of = bytes[idx];
    else                  data_of = DATA_COMMIT;
  endfunction

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    snap_d  = snap_q;
    tmr_d   = tmr_q;
    req_d   = wr_req;
    addr_d  = wr_addr;
    data_d  = wr_data;
    busy_d  = busy;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && sel != 2'b00) begin
          snap_d  = live;
          tmr_d   = sel[1];
          idx_d   = sel[0] ? 4'd0 : IDX_TMR;
          // First write comes from the live bytes, which equal the snapshot being taken.
          addr_d  = addr_of(idx_d);
          data_d  = data_of(idx_d, live);
          req_d   = 1'b1;
          busy_d  = 1'b1;
          cnt_d   = 8'd0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (wr_ack) begin
          req_d = 1'b0;
          cnt_d = 8'd0;
          if (idx_q == IDX_COMMIT) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = DONE;
          end else begin
            state_d = GAP;
          end
        end else if (cnt_q == TIMEOUT_LAST) begin
          req_d   = 1'b0;
          cnt_d   = 8'd0;
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = ERR;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      GAP: begin
        idx_d   = (idx_q == IDX_DT_LAST && !tmr_q) ? IDX_COMMIT : 4'(idx_q + 4'd1);
        addr_d  = addr_of(idx_d);
        data_d  = data_of(idx_d, snap_q);
        req_d   = 1'b1;
        state_d = REQ;
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      cnt_q   <= 8'd0;
      snap_q  <= '0;
      tmr_q   <= 1'b0;
      wr_req  <= 1'b0;
      wr_addr <= 8'd0;
      wr_data <= 8'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      snap_q  <= snap_d;
      tmr_q   <= tmr_d;
      wr_req  <= req_d;
      wr_addr <= addr_d;
      wr_data <= data_d;
      busy    <= busy_d;
      done    <= done_d;
      err     <= err_d;
    end
  end

endmodule
`default_nettype wire
